// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks WIDTH-bit operands LSB first.
// Optional: define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow port ovf.
//
// state | meaning
// IDLE  | waiting for start; Sum/Carry hold the last result
// RUN   | one operand bit pair added per clock, counter tracks bit index

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic             carry_q;
    logic             last_bit;

    // full adder built from two half adders
    logic ha1_sum, ha1_carry, ha2_carry;
    logic cell_sum, cell_carry;

    assign ha1_sum    = a_shift[0] ^ b_shift[0];
    assign ha1_carry  = a_shift[0] & b_shift[0];
    assign cell_sum   = ha1_sum ^ carry_q;
    assign ha2_carry  = ha1_sum & carry_q;
    assign cell_carry = ha1_carry | ha2_carry;

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            a_shift <= '0;
            b_shift <= '0;
            carry_q <= 1'b0;
            done    <= 1'b0;
            Sum     <= '0;
            Carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_shift <= A;
                        b_shift <= B;
                        carry_q <= Cin;
                        bit_cnt <= '0;
                        Sum     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    Sum     <= {cell_sum, Sum[WIDTH-1:1]};
                    carry_q <= cell_carry;
                    a_shift <= a_shift >> 1;
                    b_shift <= b_shift >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        Carry <= cell_carry;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // on the MSB, carry_q is the carry into the sign bit
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == ST_RUN && last_bit) begin
            ovf <= carry_q ^ cell_carry;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected results queued at accept, checked on done.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         busy, done;
    logic [W-1:0] Sum;
    logic         Carry;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, carry, sum}; overflow from operand/result sign bits
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        logic [W:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {v, s};
    endfunction

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sum", 64'(Sum), 64'(e[W-1:0]));
                chk("carry", 64'(Carry), 64'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", 64'(ovf), 64'(e[W+1]));
`endif
            end
        end
    end

    task automatic scramble();
        A   = W'($urandom);
        B   = W'($urandom);
        Cin = 1'($urandom);
    endtask

    // call at a negedge with the DUT idle; returns at a negedge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int cyc, busy_cnt;
        bit seen;
        logic [W+1:0] e;
        e = model(a, b, ci);
        A = a; B = b; Cin = ci; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        cyc = 0; busy_cnt = 0; seen = 0;
        while (!seen && cyc <= W + 4) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
                chk("busy_in_done", 64'(busy), 64'(0));
            end else begin
                if (busy) busy_cnt++;
                scramble();
                @(posedge clk);
                cyc++;
            end
        end
        if (!seen) @(negedge clk);
        chk("latency", 64'(cyc), 64'(W));
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        repeat (3) @(negedge clk);
        chk("hold_sum", 64'(Sum), 64'(e[W-1:0]));
        chk("hold_done", 64'(done), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(Sum), 64'(0));
        chk("rst_carry", 64'(Carry), 64'(0));

        do_op(8'h3C, 8'h0F, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h80, 8'hFF, 1'b0);
        do_op(8'h00, 8'h00, 1'b0);

        // start held high; next operands presented in each done cycle
        A = 8'h12; B = 8'h34; Cin = 1'b1; start = 1'b1;
        exp_q.push_back(model(A, B, Cin));
        for (int i = 0; i < 6; i++) begin
            cyc = 0;
            do begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (!done) scramble();
            end while (!done && cyc <= W + 4);
            chk("b2b_period", 64'(cyc), 64'(W + 1));
            if (i < 5) begin
                scramble();
                exp_q.push_back(model(A, B, Cin));
            end else begin
                start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        // reset during RUN bit 4: aborted op never completes
        A = 8'hA5; B = 8'h5A; Cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(Sum), 64'(0));
        chk("abort_carry", 64'(Carry), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
        chk("abort_ovf", 64'(ovf), 64'(0));
`endif
        repeat (W + 2) @(negedge clk);
        do_op(8'hC3, 8'h4D, 1'b1);

        // reset and start on the same edge: start dropped
        A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'(0));
        repeat (W + 2) @(negedge clk);
        chk("rst_start_idle", 64'(busy), 64'(0));

        for (int i = 0; i < 300; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
